// File: rtl/if_fetch_ctrl.sv
// if_fetch_ctrl: IF-stage sequencer driving PC controls, imem req/ack handshake and the IF/ID instruction buffer
module if_fetch_ctrl #(
  parameter int BOOT_DELAY = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  input  logic             stall,
  input  logic             br_taken,
  output logic             PCWrite,
  output logic             PCSel,
  output logic             ifid_flush,
  output logic [31:0]      instr,
  output logic             instr_valid,
  output logic [CNT_W-1:0] redirect_cnt
);
  localparam int BW = BOOT_DELAY > 1 ? $clog2(BOOT_DELAY) : 1;
  typedef enum logic [1:0] {BOOT, FETCH, HOLD, KILL} state_t;
  state_t state;
  logic [BW-1:0] boot_cnt;
  logic redir, capture;
  // HOLD only raises a request once stall drops and no redirect is pending, so a redirect from HOLD never leaves a request in flight
  always_comb begin
    redir = !rst && state != BOOT && br_taken;
    imem_req = !rst && (state == FETCH || state == KILL || (state == HOLD && !stall && !br_taken));
    capture = imem_req && state != KILL && imem_ack && !br_taken;
    PCWrite = redir || capture;
    PCSel = redir;
    ifid_flush = redir;
  end
  // State, instruction buffer and redirect counter; redirect outranks capture and stall
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= BOOT;
      boot_cnt <= '0;
      instr <= 32'h0000_0013;
      instr_valid <= 1'b0;
      redirect_cnt <= '0;
    end else if (state == BOOT) begin
      if (boot_cnt == BW'(BOOT_DELAY - 1)) state <= FETCH;
      else boot_cnt <= boot_cnt + 1'b1;
    end else if (redir) begin
      state <= (imem_req && !imem_ack) ? KILL : FETCH;
      instr_valid <= 1'b0;
      redirect_cnt <= redirect_cnt + 1'b1;
    end else if (capture) begin
      instr <= imem_rdata;
      instr_valid <= 1'b1;
      state <= stall ? HOLD : FETCH;
    end else if (imem_req) begin
      instr_valid <= 1'b0;
      state <= (state == KILL && !imem_ack) ? KILL : FETCH;
    end
  end
endmodule

// File: tb/tb_if_fetch_ctrl.sv
// tb_if_fetch_ctrl: directed scenarios for the IF fetch controller
module tb_if_fetch_ctrl;
  logic clk = 0, rst = 1, imem_ack = 0, stall = 0, br_taken = 0;
  logic [31:0] imem_rdata = '0;
  logic imem_req, PCWrite, PCSel, ifid_flush, instr_valid;
  logic [31:0] instr;
  logic [15:0] redirect_cnt;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  if_fetch_ctrl #(.BOOT_DELAY(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .br_taken(br_taken), .PCWrite(PCWrite), .PCSel(PCSel), .ifid_flush(ifid_flush),
    .instr(instr), .instr_valid(instr_valid), .redirect_cnt(redirect_cnt)
  );

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic a, input logic s, input logic b, input logic [31:0] d);
    imem_ack = a;
    stall = s;
    br_taken = b;
    imem_rdata = d;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    repeat (2) next();
    @(negedge clk);
    total++;
    if ({imem_req, PCWrite, PCSel, ifid_flush} !== 4'b0000) begin
      bad++;
      $display("FAIL reset_comb got=%b exp=0000", {imem_req, PCWrite, PCSel, ifid_flush});
    end
    total++;
    if (instr !== 32'h0000_0013 || instr_valid !== 1'b0 || redirect_cnt !== 16'd0) begin
      bad++;
      $display("FAIL reset_regs got instr=%h v=%b cnt=%0d exp 00000013/0/0", instr, instr_valid, redirect_cnt);
    end
    next();
  endtask

  task automatic test_boot();
    rst = 0;
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, 1'b0, c == 2, 32'h100 + 32'(c));
      @(negedge clk);
      total++;
      if ({imem_req, PCWrite, PCSel, ifid_flush} !== {c >= 4, c >= 4, 1'b0, 1'b0}) begin
        bad++;
        $display("FAIL boot_comb c=%0d got=%b exp=%b", c, {imem_req, PCWrite, PCSel, ifid_flush}, {c >= 4, c >= 4, 2'b00});
      end
      total++;
      if (instr_valid !== (c >= 5) || (c >= 5 && instr !== 32'h100 + 32'(c - 1))) begin
        bad++;
        $display("FAIL boot_instr c=%0d got v=%b instr=%h exp v=%b", c, instr_valid, instr, c >= 5);
      end
      next();
    end
    total++;
    if (redirect_cnt !== 16'd0) begin
      bad++;
      $display("FAIL boot_br_ignored got cnt=%0d exp 0", redirect_cnt);
    end
  endtask

  task automatic test_latency();
    bit ack [4] = '{0, 1, 0, 1};
    bit vld [4] = '{1, 0, 1, 0};
    for (int c = 0; c < 4; c++) begin
      drive(ack[c], 1'b0, 1'b0, ack[c] ? 32'h0050_0093 : 32'hFFFF_FFFF);
      @(negedge clk);
      total++;
      if ({imem_req, PCWrite, PCSel} !== {1'b1, ack[c], 1'b0}) begin
        bad++;
        $display("FAIL latency_comb c=%0d got=%b exp=%b", c, {imem_req, PCWrite, PCSel}, {1'b1, ack[c], 1'b0});
      end
      total++;
      if (instr_valid !== vld[c] || (c == 2 && instr !== 32'h0050_0093)) begin
        bad++;
        $display("FAIL latency_instr c=%0d got v=%b instr=%h exp v=%b", c, instr_valid, instr, vld[c]);
      end
      next();
    end
  endtask

  task automatic test_stall();
    bit ack [6] = '{1, 1, 1, 1, 1, 0};
    bit stl [6] = '{1, 1, 1, 1, 0, 0};
    bit req [6] = '{1, 0, 0, 0, 1, 1};
    bit pcw [6] = '{1, 0, 0, 0, 1, 0};
    logic [31:0] dat [6] = '{32'h1111_1111, 32'h2222_2222, 32'h2222_2222, 32'h2222_2222, 32'h3333_3333, 32'h0};
    for (int c = 0; c < 6; c++) begin
      drive(ack[c], stl[c], 1'b0, dat[c]);
      @(negedge clk);
      total++;
      if ({imem_req, PCWrite, PCSel} !== {req[c], pcw[c], 1'b0}) begin
        bad++;
        $display("FAIL stall_comb c=%0d got=%b exp=%b", c, {imem_req, PCWrite, PCSel}, {req[c], pcw[c], 1'b0});
      end
      if (c > 0) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== (c == 5 ? 32'h3333_3333 : 32'h1111_1111)) begin
          bad++;
          $display("FAIL stall_instr c=%0d got v=%b instr=%h", c, instr_valid, instr);
        end
      end
      next();
    end
  endtask

  task automatic test_kill();
    bit br [6] = '{1, 0, 0, 0, 0, 0};
    bit ack [6] = '{0, 0, 1, 0, 1, 1};
    logic [3:0] ec [6] = '{4'b1111, 4'b1000, 4'b1000, 4'b1000, 4'b1100, 4'b1100};
    bit vld [6] = '{0, 0, 0, 0, 0, 1};
    logic [31:0] dat [6] = '{32'h0, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h4444_4444, 32'h5555_5555};
    for (int c = 0; c < 6; c++) begin
      drive(ack[c], 1'b0, br[c], dat[c]);
      @(negedge clk);
      total++;
      if ({imem_req, PCWrite, PCSel, ifid_flush} !== ec[c]) begin
        bad++;
        $display("FAIL kill_comb c=%0d got=%b exp=%b", c, {imem_req, PCWrite, PCSel, ifid_flush}, ec[c]);
      end
      total++;
      if (instr_valid !== vld[c] || instr === 32'hDEAD_BEEF || (c == 5 && instr !== 32'h4444_4444)) begin
        bad++;
        $display("FAIL kill_instr c=%0d got v=%b instr=%h exp v=%b", c, instr_valid, instr, vld[c]);
      end
      if (c > 0) begin
        total++;
        if (redirect_cnt !== 16'd1) begin
          bad++;
          $display("FAIL kill_cnt c=%0d got=%0d exp=1", c, redirect_cnt);
        end
      end
      next();
    end
  endtask

  task automatic test_back_to_back();
    bit br [5] = '{1, 0, 1, 1, 0};
    bit stl [5] = '{1, 1, 0, 0, 0};
    bit ack [5] = '{1, 0, 0, 0, 0};
    logic [3:0] ec [5] = '{4'b1111, 4'b1000, 4'b1111, 4'b1111, 4'b1000};
    int cnt [5] = '{1, 2, 2, 3, 4};
    for (int c = 0; c < 5; c++) begin
      drive(ack[c], stl[c], br[c], 32'h6666_6666);
      @(negedge clk);
      total++;
      if ({imem_req, PCWrite, PCSel, ifid_flush} !== ec[c]) begin
        bad++;
        $display("FAIL b2b_comb c=%0d got=%b exp=%b", c, {imem_req, PCWrite, PCSel, ifid_flush}, ec[c]);
      end
      total++;
      if (redirect_cnt !== 16'(cnt[c]) || instr_valid !== (c == 0) || instr !== 32'h5555_5555) begin
        bad++;
        $display("FAIL b2b_regs c=%0d got cnt=%0d v=%b instr=%h exp cnt=%0d", c, redirect_cnt, instr_valid, instr, cnt[c]);
      end
      next();
    end
  endtask

  task automatic test_rst_mid();
    drive(1'b0, 1'b0, 1'b0, 32'h0);
    rst = 1;
    #1;
    total++;
    if ({imem_req, PCWrite, instr_valid} !== 3'b000 || redirect_cnt !== 16'd0 || instr !== 32'h0000_0013) begin
      bad++;
      $display("FAIL rst_async got req=%b pcw=%b v=%b cnt=%0d instr=%h", imem_req, PCWrite, instr_valid, redirect_cnt, instr);
    end
    next();
    next();
    rst = 0;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 1'b0, 1'b0, 32'h7000_0000 + 32'(c));
      @(negedge clk);
      total++;
      if (imem_req !== (c >= 4) || instr_valid !== (c >= 5) || redirect_cnt !== 16'd0) begin
        bad++;
        $display("FAIL rst_reboot c=%0d got req=%b v=%b cnt=%0d", c, imem_req, instr_valid, redirect_cnt);
      end
      next();
    end
  endtask

  initial begin
    test_reset();
    test_boot();
    test_latency();
    test_stall();
    test_kill();
    test_back_to_back();
    test_rst_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
